// File: rtl/uart_calc_client.sv
// uart_calc_client: host-side initiator for the UART calculator protocol.
// Sends A, B and OP as twelve 8N1 bytes, then collects a 4-byte result.
module uart_calc_client #(
    parameter int CYCLES_PER_BIT = 104,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic        frame_err
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [67:0]   words_q, words_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    tbit_q, tbit_d;
    logic [CW-1:0] tcyc_q, tcyc_d;
    logic          tx_q, tx_d;
    logic          s1_q, s2_q, prev_q;
    logic          ract_q, ract_d;
    logic [3:0]    rbit_q, rbit_d;
    logic [CW-1:0] rcyc_q, rcyc_d;
    logic [7:0]    rsh_q, rsh_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   result_q, result_d;
    logic          rv_q, rv_d;
    logic          tmo_q, tmo_d;
    logic          fe_q, fe_d;

    logic [95:0]   wire_w;
    logic [7:0]    tx_byte;
    logic          rx_fall;
    logic [CW-1:0] rx_last;

    // Bytes 9..11 are the zero upper bytes of the OP word.
    assign wire_w  = {28'b0, words_q};
    assign tx_byte = wire_w[{idx_q, 3'b000} +: 8];
    assign rx_fall = prev_q && !s2_q;
    assign rx_last = (rbit_q == 4'd0) ? HALF_LAST : BIT_LAST;

    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        idx_d    = idx_q;
        tbit_d   = tbit_q;
        tcyc_d   = tcyc_q;
        tx_d     = tx_q;
        ract_d   = ract_q;
        rbit_d   = rbit_q;
        rcyc_d   = rcyc_q;
        rsh_d    = rsh_q;
        rcnt_d   = rcnt_q;
        shadow_d = shadow_q;
        to_d     = to_q;
        result_d = result_q;
        rv_d     = 1'b0;
        tmo_d    = 1'b0;
        fe_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    words_d = {op, b, a};
                    idx_d   = 4'd0;
                    tbit_d  = 4'd0;
                    tcyc_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            S_SEND: begin
                if (tcyc_q == BIT_LAST) begin
                    tcyc_d = '0;
                    if (tbit_q == 4'd9) begin
                        tbit_d = 4'd0;
                        if (idx_q == 4'd11) begin
                            state_d = S_RECV;
                            tx_d    = 1'b1;
                            to_d    = '0;
                            ract_d  = 1'b0;
                            rcnt_d  = 2'd0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                            tx_d  = 1'b0;
                        end
                    end else begin
                        tbit_d = tbit_q + 4'd1;
                        tx_d   = (tbit_q == 4'd8) ? 1'b1
                                                  : tx_byte[tbit_q[2:0]];
                    end
                end else begin
                    tcyc_d = tcyc_q + 1'b1;
                end
            end
            S_RECV: begin
                if (!ract_q) begin
                    if (rx_fall) begin
                        ract_d = 1'b1;
                        rcyc_d = '0;
                        rbit_d = 4'd0;
                        to_d   = '0;
                    end else if (to_q == TO_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end else if (rcyc_q == rx_last) begin
                    rcyc_d = '0;
                    rbit_d = rbit_q + 4'd1;
                    if (rbit_q == 4'd0) begin
                        // Line back high at the start check: a glitch.
                        if (s2_q) ract_d = 1'b0;
                    end else if (rbit_q == 4'd9) begin
                        ract_d = 1'b0;
                        if (!s2_q) begin
                            fe_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            shadow_d = {rsh_q, shadow_q[31:8]};
                            rcnt_d   = rcnt_q + 2'd1;
                            if (rcnt_q == 2'd3) state_d = S_DONE;
                        end
                    end else begin
                        rsh_d = {s2_q, rsh_q[7:1]};
                    end
                end else begin
                    rcyc_d = rcyc_q + 1'b1;
                end
            end
            S_DONE: begin
                result_d = shadow_q;
                rv_d     = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            words_q  <= '0;
            idx_q    <= '0;
            tbit_q   <= '0;
            tcyc_q   <= '0;
            tx_q     <= 1'b1;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            prev_q   <= 1'b1;
            ract_q   <= 1'b0;
            rbit_q   <= '0;
            rcyc_q   <= '0;
            rsh_q    <= '0;
            rcnt_q   <= '0;
            shadow_q <= '0;
            to_q     <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            tmo_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            idx_q    <= idx_d;
            tbit_q   <= tbit_d;
            tcyc_q   <= tcyc_d;
            tx_q     <= tx_d;
            s1_q     <= rx;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            ract_q   <= ract_d;
            rbit_q   <= rbit_d;
            rcyc_q   <= rcyc_d;
            rsh_q    <= rsh_d;
            rcnt_q   <= rcnt_d;
            shadow_q <= shadow_d;
            to_q     <= to_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            tmo_q    <= tmo_d;
            fe_q     <= fe_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = rv_q;
    assign timeout      = tmo_q;
    assign frame_err    = fe_q;
endmodule

// File: tb/tb_uart_calc_client.sv
// Directed bench for uart_calc_client: decodes tx frames,
// answers on rx and watches the result and error pulses.
module tb_uart_calc_client;
    localparam int CPB = 8;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  op = '0;
    logic        tx, busy, result_valid, timeout, frame_err;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rv_n = 0;
    int to_n = 0;
    int fe_n = 0;
    int to_at = 0;
    int t0 = 0;

    uart_calc_client #(
        .CYCLES_PER_BIT(CPB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .op(op),
        .rx(rx),
        .tx(tx),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .timeout(timeout),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid) rv_n++;
        if (timeout) begin
            to_n++;
            to_at = cyc;
        end
        if (frame_err) fe_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic get_byte(output logic [7:0] d, output logic stp);
        int n;
        n = 0;
        d = 8'h00;
        stp = 1'b0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            chk("tx_start_seen", 32'(tx), 32'd0);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
    endtask

    // Issue a command and decode the first nb bytes on tx.
    task automatic cmd(input logic [31:0] pa, input logic [31:0] pb,
                       input logic [3:0] pop, input int nb,
                       input bit poke);
        logic [95:0] w;
        logic [7:0]  d;
        logic        s;
        w = {28'b0, pop, pb, pa};
        a = pa;
        b = pb;
        op = pop;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("tx_first_start", 32'(tx), 32'd0);
        for (int k = 0; k < nb; k++) begin
            get_byte(d, s);
            chk($sformatf("tx_byte%0d", k), 32'(d), 32'(w[k*8 +: 8]));
            chk($sformatf("tx_stop%0d", k), 32'(s), 32'd1);
            if (poke && k == 2) begin
                a = ~pa;
                b = ~pb;
                op = ~pop;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stp);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stp;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic reply(input logic [31:0] r, input int pre);
        repeat (pre) @(negedge clk);
        for (int k = 0; k < 4; k++) send_byte(r[k*8 +: 8], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    int rv0, to0, fe0, lows;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'b0, result_valid, timeout, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Add: 5 + 3
        rv0 = rv_n;
        cmd(32'd5, 32'd3, 4'd0, 12, 1'b0);
        reply(32'h0000_0008, 8);
        chk("add_result", result, 32'h0000_0008);
        chk("add_rv_pulses", 32'(rv_n - rv0), 32'd1);
        chk("add_busy_low", 32'(busy), 32'd0);

        // Byte order
        rv0 = rv_n;
        cmd(32'h1234_5678, 32'hDEAD_BEEF, 4'hA, 12, 1'b0);
        reply(32'hDEAD_BEEF, 8);
        chk("order_result", result, 32'hDEAD_BEEF);
        chk("order_rv_pulses", 32'(rv_n - rv0), 32'd1);

        // Timeout with no reply
        to0 = to_n;
        rv0 = rv_n;
        cmd(32'd1, 32'd1, 4'd1, 12, 1'b0);
        for (int n = 0; n < 400 && to_n == to0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("tmo_pulses", 32'(to_n - to0), 32'd1);
        chk("tmo_cycle", 32'(to_at - t0), 32'(120 * CPB + TMO));
        chk("tmo_result_kept", result, 32'hDEAD_BEEF);
        chk("tmo_no_rv", 32'(rv_n - rv0), 32'd0);
        chk("tmo_busy_low", 32'(busy), 32'd0);

        // Framing error on the second reply byte
        fe0 = fe_n;
        rv0 = rv_n;
        cmd(32'd7, 32'd9, 4'd2, 12, 1'b0);
        repeat (8) @(negedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        chk("fe_pulses", 32'(fe_n - fe0), 32'd1);
        chk("fe_no_rv", 32'(rv_n - rv0), 32'd0);
        chk("fe_busy_low", 32'(busy), 32'd0);
        chk("fe_result_kept", result, 32'hDEAD_BEEF);

        // Following good transaction
        rv0 = rv_n;
        cmd(32'd100, 32'd200, 4'd0, 12, 1'b0);
        reply(32'h0000_012C, 8);
        chk("post_fe_result", result, 32'h0000_012C);
        chk("post_fe_rv", 32'(rv_n - rv0), 32'd1);

        // start during SEND is ignored
        rv0 = rv_n;
        cmd(32'h1122_3344, 32'h5566_7788, 4'h3, 12, 1'b1);
        reply(32'hCAFE_0001, 8);
        chk("poke_result", result, 32'hCAFE_0001);
        chk("poke_rv", 32'(rv_n - rv0), 32'd1);
        lows = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) lows++;
        end
        chk("poke_not_queued", 32'(lows), 32'd0);

        // Glitch on rx in RECV
        rv0 = rv_n;
        to0 = to_n;
        fe0 = fe_n;
        cmd(32'd2, 32'd2, 4'd0, 12, 1'b0);
        repeat (8) @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_no_rv", 32'(rv_n - rv0), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd1);
        reply(32'h0000_0004, 0);
        chk("glitch_result", result, 32'h0000_0004);
        chk("glitch_rv", 32'(rv_n - rv0), 32'd1);
        chk("glitch_flags", 32'((to_n - to0) + (fe_n - fe0)), 32'd0);

        // Reset during the sixth byte
        cmd(32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'h5, 5, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_flags",
            {29'b0, result_valid, timeout, frame_err}, 32'd0);
        rst = 1'b0;
        lows = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("post_rst_idle", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_calc_client.md
# uart_calc_client

Host-side initiator for the UART calculator protocol: latches two 32-bit operands and a 4-bit opcode, serialises them as twelve 8N1 bytes on `tx`, then receives the four-byte 32-bit result on `rx`. Contains its own 8N1 transmitter and receiver, with no dependency on `uart_tx`/`uart_rx`. Used as the driver in board-to-board tests and as a synthesizable stimulus source in the calculator testbench. Also usable on a second FPGA facing the calculator.

## Interface
Parameters:
- `CYCLES_PER_BIT`, 104: clk cycles per UART bit; must be ≥ 4.
- `TIMEOUT_CYCLES`, 65536: maximum idle cycles allowed while waiting for a result byte.

Ports:
- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `a`  in  32  operand A, latched on accepted `start`.
- `b`  in  32  operand B, latched on accepted `start`.
- `op`  in  4  opcode, latched on accepted `start`.
- `rx`  in  1  serial input from the calculator; asynchronous, idle high.
- `tx`  out  1  serial output to the calculator; idle high.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `result`  out  32  last received result; holds its value until the next completed result.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `timeout`  out  1  one-cycle pulse on a response timeout.
- `frame_err`  out  1  one-cycle pulse when a received stop bit is low.

## Operation
- Reset values: `tx`=1, `busy`=0, `result`=0, `result_valid`=0, `timeout`=0, `frame_err`=0, FSM in IDLE.
- Word order on the wire: A, then B, then OP word (`{28'b0, op}`). Each word is sent least-significant byte first, matching `word_rx`/`word_tx`.
- Byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CYCLES_PER_BIT` clks.
- FSM states:
  - IDLE: `start`=1 latches `a`/`b`/`op`, clears the byte index to 0 and goes to SEND.
  - SEND: transmits byte[index]. After the stop bit of byte 11 it goes to RECV; otherwise it increments the index and continues.
  - RECV: receives 4 bytes into `result` shadow bytes 0..3. The 4th good byte goes to DONE.
  - DONE: single cycle. Copies the shadow to `result`, pulses `result_valid`, then goes to IDLE.
  - On timeout or framing error: pulse the matching flag, discard partial bytes, go to IDLE. `result` is unchanged.
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - Start is detected on a high-to-low transition of the synchronized `rx`. It is re-checked at `CYCLES_PER_BIT/2`; if high there, it is a glitch and is ignored.
  - Data bits are sampled at mid-bit, every `CYCLES_PER_BIT` after the start check.
  - The stop bit is sampled at mid-bit. If it is low, `frame_err` pulses.
  - The receiver is enabled only in RECV. Traffic on `rx` during IDLE/SEND is ignored.
- Timeout counter:
  - Cleared on entry to RECV and on each detected start bit.
  - Increments every cycle in RECV while no byte is in progress.
  - When the count reaches `TIMEOUT_CYCLES`, `timeout` pulses.
- `start` while `busy` is ignored and is not queued.
- Reset mid-transaction: `tx` returns to 1 on the next clk edge and all state clears. Any partial frame already on the line is truncated.

## Timing
- Accepted `start` at edge N:
  - `busy`=1 and `tx`=0 (start bit of byte 0) from edge N+1.
  - Bytes are sent back-to-back with no idle bits.
  - The stop bit of byte 11 ends at edge N+1+120·`CYCLES_PER_BIT`, and RECV is entered at that edge.
- `result_valid` rises one clk after the mid-bit sample of the 4th result stop bit. `result` is valid in that same cycle.
- `busy` falls in the cycle after DONE, timeout or frame_err. A new `start` is accepted in that same cycle.
- Synchronizer latency: 2 clks from an `rx` edge to start detection.

## Test plan
- Add: `CYCLES_PER_BIT`=8, `a`=5, `b`=3, `op`=0.
  - Bench decodes on `tx`: 05 00 00 00 03 00 00 00 00 00 00 00, each framed 0,data,1.
  - Bench replies 08 00 00 00.
  - Required: `result`=0x00000008 with a single `result_valid` pulse, then `busy`=0.
- Byte order: `a`=0x12345678, `b`=0xDEADBEEF, `op`=0xA.
  - Required: first tx byte 0x78, 5th byte 0xEF, 9th byte 0x0A, bytes 10–12 0x00.
  - Reply 0xEF,0xBE,0xAD,0xDE → `result`=0xDEADBEEF.
- Timeout: `TIMEOUT_CYCLES`=100, no reply.
  - Required: `timeout` pulses exactly 100 clks after RECV entry, `result` unchanged, `busy`=0.
- Framing error: 2nd reply byte sent with stop bit 0.
  - Required: `frame_err` pulse, no `result_valid`, return to IDLE.
  - A following correct transaction completes normally.
- Reset and busy behaviour:
  - Pulse `start` again during SEND → ignored; tx byte sequence unchanged.
  - Assert `rst` during byte 6 → `tx`=1 and `busy`=0 on the next edge; all outputs at reset values.
- Glitch rejection: a 2-clk low pulse on `rx` in RECV produces no byte and no flags. The timeout counter is only cleared once, at the glitch's detected edge, and not otherwise affected.
